// File: rtl/instr_encoder.sv
// RV32 instruction encoder: turns field-level requests (or an LI pseudo-op) into
// one or two encoded words, with a valid/ready handshake on both sides.
module instr_encoder (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_req_valid,
    output logic        o_req_ready,
    input  logic [6:0]  i_opcode,
    input  logic [2:0]  i_funct3,
    input  logic [6:0]  i_funct7,
    input  logic [4:0]  i_rd,
    input  logic [4:0]  i_rs1,
    input  logic [4:0]  i_rs2,
    input  logic [31:0] i_imm,
    input  logic        i_li,
    output logic        o_instr_valid,
    input  logic        i_instr_ready,
    output logic [31:0] o_instr,
    output logic        o_err,
    output logic [15:0] o_count
);

    localparam logic [6:0] OPCODE_R      = 7'b0110011;
    localparam logic [6:0] OPCODE_I      = 7'b0010011;
    localparam logic [6:0] OPCODE_LOAD   = 7'b0000011;
    localparam logic [6:0] OPCODE_JALR   = 7'b1100111;
    localparam logic [6:0] OPCODE_STORE  = 7'b0100011;
    localparam logic [6:0] OPCODE_PIM    = 7'b0001011;
    localparam logic [6:0] OPCODE_BRANCH = 7'b1100011;
    localparam logic [6:0] OPCODE_JAL    = 7'b1101111;
    localparam logic [6:0] OPCODE_LUI    = 7'b0110111;
    localparam logic [6:0] OPCODE_AUIPC  = 7'b0010111;

    typedef enum logic [1:0] {IDLE, OUT1, OUT2} state_t;

    state_t      state, state_next;
    logic [31:0] pending;
    logic        has_second;
    logic [31:0] word1, word2;
    logic        two_words, legal;
    logic        accept, handshake;
    logic        fits12, fits13, fits21, low12_zero;
    logic [19:0] li_hi;

    // Sign-extension checks: a value fits N bits iff all bits above N-1 match bit N-1.
    assign fits12     = (&i_imm[31:11]) | ~(|i_imm[31:11]);
    assign fits13     = (&i_imm[31:12]) | ~(|i_imm[31:12]);
    assign fits21     = (&i_imm[31:20]) | ~(|i_imm[31:20]);
    assign low12_zero = ~(|i_imm[11:0]);
    // Upper part of (imm + 0x800) >> 12: the add only carries into bit 12 when imm[11] is set.
    assign li_hi      = i_imm[31:12] + {19'd0, i_imm[11]};

    always_comb begin
        word1     = '0;
        word2     = '0;
        two_words = 1'b0;
        legal     = 1'b0;
        if (i_li) begin
            legal = 1'b1;
            if (fits12) begin
                word1 = {i_imm[11:0], 5'd0, 3'b000, i_rd, OPCODE_I};
            end else if (low12_zero) begin
                word1 = {i_imm[31:12], i_rd, OPCODE_LUI};
            end else begin
                word1     = {li_hi, i_rd, OPCODE_LUI};
                word2     = {i_imm[11:0], i_rd, 3'b000, i_rd, OPCODE_I};
                two_words = 1'b1;
            end
        end else begin
            unique case (i_opcode)
                OPCODE_R: begin
                    legal = 1'b1;
                    word1 = {i_funct7, i_rs2, i_rs1, i_funct3, i_rd, i_opcode};
                end
                OPCODE_I: begin
                    if (i_funct3 == 3'b001 || i_funct3 == 3'b101) begin
                        legal = ~(|i_imm[31:5]);
                        word1 = {i_funct7, i_imm[4:0], i_rs1, i_funct3, i_rd, i_opcode};
                    end else begin
                        legal = fits12;
                        word1 = {i_imm[11:0], i_rs1, i_funct3, i_rd, i_opcode};
                    end
                end
                OPCODE_LOAD, OPCODE_JALR: begin
                    legal = fits12;
                    word1 = {i_imm[11:0], i_rs1, i_funct3, i_rd, i_opcode};
                end
                OPCODE_STORE, OPCODE_PIM: begin
                    legal = fits12;
                    word1 = {i_imm[11:5], i_rs2, i_rs1, i_funct3, i_imm[4:0], i_opcode};
                end
                OPCODE_BRANCH: begin
                    legal = fits13 & ~i_imm[0];
                    word1 = {i_imm[12], i_imm[10:5], i_rs2, i_rs1, i_funct3,
                             i_imm[4:1], i_imm[11], i_opcode};
                end
                OPCODE_JAL: begin
                    legal = fits21 & ~i_imm[0];
                    word1 = {i_imm[20], i_imm[10:1], i_imm[11], i_imm[19:12], i_rd, i_opcode};
                end
                OPCODE_LUI, OPCODE_AUIPC: begin
                    legal = low12_zero;
                    word1 = {i_imm[31:12], i_rd, i_opcode};
                end
                default: legal = 1'b0;
            endcase
        end
    end

    assign accept    = (state == IDLE) && i_req_valid;
    assign handshake = o_instr_valid && i_instr_ready;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state <= IDLE;
        else          state <= state_next;
    end

    always_comb begin
        state_next    = state;
        o_req_ready   = 1'b0;
        o_instr_valid = 1'b0;
        unique case (state)
            IDLE: begin
                o_req_ready = i_rst_n;
                if (i_req_valid && legal) state_next = OUT1;
            end
            OUT1: begin
                o_instr_valid = 1'b1;
                if (i_instr_ready) state_next = has_second ? OUT2 : IDLE;
            end
            OUT2: begin
                o_instr_valid = 1'b1;
                if (i_instr_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_instr    <= '0;
            pending    <= '0;
            has_second <= 1'b0;
            o_err      <= 1'b0;
            o_count    <= '0;
        end else begin
            o_err <= accept && !legal;
            if (accept && legal) begin
                o_instr    <= word1;
                pending    <= word2;
                has_second <= two_words;
            end else if (state == OUT1 && handshake && has_second) begin
                o_instr <= pending;
            end
            if (handshake && o_count != '1) o_count <= o_count + 16'd1;
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
// Directed and randomized checks of instr_encoder against an arithmetic
// reference model of the encoding and range rules.
module tb_instr_encoder;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_PIM    = 7'b0001011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready, li, instr_valid, instr_ready, err;
    logic [6:0]  opcode, funct7;
    logic [2:0]  funct3;
    logic [4:0]  rd, rs1, rs2;
    logic [31:0] imm, instr;
    logic [15:0] count;

    int compared   = 0;
    int mismatched = 0;
    int exp_count  = 0;

    logic [6:0]  ops [10] = '{OP_R, OP_I, OP_LOAD, OP_JALR, OP_STORE,
                              OP_PIM, OP_BRANCH, OP_JAL, OP_LUI, OP_AUIPC};
    int          bnd [14] = '{2047, 2048, -2048, -2049, 4094, 4095, 4096, -4096,
                              -4098, 1048574, 1048576, -1048576, -1048578, 31};

    always #5 clk = ~clk;

    instr_encoder dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_req_valid   (req_valid),
        .o_req_ready   (req_ready),
        .i_opcode      (opcode),
        .i_funct3      (funct3),
        .i_funct7      (funct7),
        .i_rd          (rd),
        .i_rs1         (rs1),
        .i_rs2         (rs2),
        .i_imm         (imm),
        .i_li          (li),
        .o_instr_valid (instr_valid),
        .i_instr_ready (instr_ready),
        .o_instr       (instr),
        .o_err         (err),
        .o_count       (count)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic void model(input logic l, input logic [6:0] op, input logic [2:0] f3,
                                  input logic [6:0] f7, input logic [4:0] d, input logic [4:0] s1,
                                  input logic [4:0] s2, input logic [31:0] v,
                                  output bit ok, output int n,
                                  output logic [31:0] w1, output logic [31:0] w2);
        int          s;
        logic [31:0] hi;
        s  = $signed(v);
        ok = 1'b1;
        n  = 1;
        w1 = '0;
        w2 = '0;
        if (l) begin
            if (s >= -2048 && s <= 2047) begin
                w1 = {v[11:0], 5'd0, 3'd0, d, OP_I};
            end else if (v % 4096 == 0) begin
                w1 = {v[31:12], d, OP_LUI};
            end else begin
                hi = (v + 32'h800) / 4096;
                w1 = {hi[19:0], d, OP_LUI};
                w2 = {v[11:0], d, 3'd0, d, OP_I};
                n  = 2;
            end
        end else begin
            case (op)
                OP_R: w1 = {f7, s2, s1, f3, d, op};
                OP_I: begin
                    if (f3 == 3'd1 || f3 == 3'd5) begin
                        ok = (v < 32);
                        w1 = {f7, v[4:0], s1, f3, d, op};
                    end else begin
                        ok = (s >= -2048 && s <= 2047);
                        w1 = {v[11:0], s1, f3, d, op};
                    end
                end
                OP_LOAD, OP_JALR: begin
                    ok = (s >= -2048 && s <= 2047);
                    w1 = {v[11:0], s1, f3, d, op};
                end
                OP_STORE, OP_PIM: begin
                    ok = (s >= -2048 && s <= 2047);
                    w1 = {v[11:5], s2, s1, f3, v[4:0], op};
                end
                OP_BRANCH: begin
                    ok = (s >= -4096 && s <= 4094 && v % 2 == 0);
                    w1 = {v[12], v[10:5], s2, s1, f3, v[4:1], v[11], op};
                end
                OP_JAL: begin
                    ok = (s >= -1048576 && s <= 1048574 && v % 2 == 0);
                    w1 = {v[20], v[10:1], v[11], v[19:12], d, op};
                end
                OP_LUI, OP_AUIPC: begin
                    ok = (v % 4096 == 0);
                    w1 = {v[31:12], d, op};
                end
                default: ok = 1'b0;
            endcase
        end
        if (!ok) n = 0;
    endfunction

    // One complete request; when use_lit is set the words are also held to literal values.
    task automatic run_req(input logic l, input logic [6:0] op, input logic [2:0] f3,
                           input logic [6:0] f7, input logic [4:0] d, input logic [4:0] s1,
                           input logic [4:0] s2, input logic [31:0] v, input int stall,
                           input bit use_lit, input logic [31:0] lit1, input logic [31:0] lit2);
        bit          ok;
        int          n;
        logic [31:0] w1, w2;
        model(l, op, f3, f7, d, s1, s2, v, ok, n, w1, w2);
        if (use_lit) begin
            w1 = lit1;
            w2 = lit2;
        end
        @(negedge clk);
        li = l; opcode = op; funct3 = f3; funct7 = f7;
        rd = d; rs1 = s1; rs2 = s2; imm = v;
        req_valid = 1'b1; instr_ready = 1'b0;
        check("req_ready_idle", req_ready, 1);
        @(negedge clk);
        req_valid = 1'b0;
        if (!ok) begin
            check("err_pulse", err, 1);
            check("valid_on_err", instr_valid, 0);
            @(negedge clk);
            check("err_one_cycle", err, 0);
            check("valid_after_err", instr_valid, 0);
            check("count_after_err", count, exp_count);
            return;
        end
        check("err_on_accept", err, 0);
        for (int k = 0; k < stall; k++) begin
            check("stall_valid", instr_valid, 1);
            check("stall_instr", instr, w1);
            check("stall_req_ready", req_ready, 0);
            @(negedge clk);
        end
        check("word1_valid", instr_valid, 1);
        check("word1", instr, w1);
        instr_ready = 1'b1;
        @(negedge clk);
        exp_count++;
        if (n == 2) begin
            check("word2_valid", instr_valid, 1);
            check("word2", instr, w2);
            @(negedge clk);
            exp_count++;
        end
        instr_ready = 1'b0;
        check("valid_done", instr_valid, 0);
        check("count", count, exp_count);
        check("req_ready_done", req_ready, 1);
    endtask

    function automatic logic [31:0] rand_imm();
        logic [31:0] v;
        case ($urandom_range(0, 5))
            0:       v = $urandom;
            1:       v = 32'(int'($urandom_range(0, 9999)) - 5000);
            2:       v = 32'(bnd[$urandom_range(0, 13)]);
            3:       v = $urandom & 32'hFFFFF000;
            4:       v = 32'($urandom_range(0, 40));
            default: v = 32'(int'($urandom_range(0, 2200000)) - 1100000);
        endcase
        return v;
    endfunction

    initial begin
        rst_n = 1'b0; req_valid = 1'b0; instr_ready = 1'b0; li = 1'b0;
        opcode = '0; funct3 = '0; funct7 = '0; rd = '0; rs1 = '0; rs2 = '0; imm = '0;
        #12;
        check("rst_req_ready", req_ready, 0);
        check("rst_valid", instr_valid, 0);
        check("rst_err", err, 0);
        check("rst_instr", instr, 0);
        check("rst_count", count, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("ready_after_release", req_ready, 1);

        run_req(0, OP_I, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'hFFFFFFFF, 3, 1, 32'hFFF00093, 0);
        run_req(1, 7'd0, 3'd0, 7'd0, 5'd5, 5'd0, 5'd0, 32'h12345FFF, 0, 1, 32'h123462B7, 32'hFFF28293);
        run_req(0, OP_BRANCH, 3'd0, 7'd0, 5'd0, 5'd1, 5'd2, 32'd8, 0, 1, 32'h00208463, 0);
        run_req(0, OP_BRANCH, 3'd0, 7'd0, 5'd0, 5'd1, 5'd2, 32'd3, 0, 0, 0, 0);
        run_req(0, OP_I, 3'd1, 7'd0, 5'd1, 5'd1, 5'd0, 32'd32, 0, 0, 0, 0);
        run_req(0, OP_I, 3'd1, 7'd0, 5'd1, 5'd1, 5'd0, 32'd31, 0, 1, 32'h01F09093, 0);
        run_req(0, OP_I, 3'd0, 7'd0, 5'd3, 5'd4, 5'd0, 32'd2047, 0, 0, 0, 0);
        run_req(0, OP_I, 3'd0, 7'd0, 5'd3, 5'd4, 5'd0, 32'd2048, 0, 0, 0, 0);
        run_req(0, OP_STORE, 3'd2, 7'd0, 5'd0, 5'd4, 5'd7, 32'hFFFFF800, 0, 0, 0, 0);
        run_req(0, OP_STORE, 3'd2, 7'd0, 5'd0, 5'd4, 5'd7, 32'hFFFFF7FF, 0, 0, 0, 0);
        run_req(0, OP_BRANCH, 3'd1, 7'd0, 5'd0, 5'd3, 5'd9, 32'd4094, 0, 0, 0, 0);
        run_req(0, OP_BRANCH, 3'd1, 7'd0, 5'd0, 5'd3, 5'd9, 32'd4096, 0, 0, 0, 0);
        run_req(0, OP_JAL, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd1048574, 0, 0, 0, 0);
        run_req(0, OP_JAL, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd1048576, 0, 0, 0, 0);
        run_req(0, OP_JAL, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'hFFF00000, 0, 0, 0, 0);
        run_req(0, OP_LUI, 3'd0, 7'd0, 5'd8, 5'd0, 5'd0, 32'h12345000, 0, 0, 0, 0);
        run_req(0, OP_AUIPC, 3'd0, 7'd0, 5'd8, 5'd0, 5'd0, 32'h12345001, 0, 0, 0, 0);
        run_req(0, 7'h7F, 3'd0, 7'd0, 5'd8, 5'd0, 5'd0, 32'd0, 0, 0, 0, 0);
        run_req(1, 7'h7F, 3'd0, 7'd0, 5'd9, 5'd0, 5'd0, 32'hFFFFF800, 0, 0, 0, 0);
        run_req(1, 7'd0, 3'd0, 7'd0, 5'd9, 5'd0, 5'd0, 32'h12345000, 0, 0, 0, 0);
        run_req(1, 7'd0, 3'd0, 7'd0, 5'd9, 5'd0, 5'd0, 32'd2048, 1, 0, 0, 0);

        // Reset while the second LI word is pending.
        @(negedge clk);
        li = 1'b1; rd = 5'd6; imm = 32'h12345FFF; req_valid = 1'b1; instr_ready = 1'b0;
        @(negedge clk);
        req_valid = 1'b0; li = 1'b0;
        check("li_rst_word1_valid", instr_valid, 1);
        instr_ready = 1'b1;
        @(negedge clk);
        check("li_rst_in_out2", instr_valid, 1);
        instr_ready = 1'b0;
        rst_n = 1'b0;
        #1;
        check("midrst_valid", instr_valid, 0);
        check("midrst_instr", instr, 0);
        check("midrst_err", err, 0);
        check("midrst_count", count, 0);
        check("midrst_req_ready", req_ready, 0);
        exp_count = 0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("midrst_ready_release", req_ready, 1);
        instr_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("no_word_after_rst", instr_valid, 0);
        end
        instr_ready = 1'b0;
        check("count_after_rst", count, 0);

        for (int it = 0; it < 300; it++) begin
            logic [6:0] rop;
            logic       rli;
            rop = ($urandom_range(0, 7) == 0) ? 7'($urandom) : ops[$urandom_range(0, 9)];
            rli = ($urandom_range(0, 3) == 0);
            run_req(rli, rop, 3'($urandom), 7'($urandom), 5'($urandom), 5'($urandom),
                    5'($urandom), rand_imm(), int'($urandom_range(0, 2)), 0, 0, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
